// File: rtl/mmio_gpio_pkg.sv
// Shared constants and helpers for the mmio_gpio block: register offsets and
// debounce counter sizing.
package mmio_gpio_pkg;

  // Register offsets relative to BASE_ADDR
  localparam logic [1:0] OFF_OUT  = 2'd0;
  localparam logic [1:0] OFF_IN   = 2'd1;
  localparam logic [1:0] OFF_EDGE = 2'd2;
  localparam logic [1:0] OFF_MASK = 2'd3;

  // Number of byte addresses decoded by the block
  localparam int unsigned REG_SPAN = 4;

  // Width of a counter that can hold 0..cycles
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// One input bit: SYNC_STAGES-deep synchroniser, polarity fix-up and, when
// MMIO_GPIO_DEBOUNCE_EN is defined, a stability counter. rise_o_c pulses on
// the cycle whose clock edge moves the stable value from 0 to 1.
module gpio_debounce #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          ACTIVE_LOW  = 1'b1
`ifdef MMIO_GPIO_DEBOUNCE_EN
  , parameter int unsigned DEBOUNCE_CYCLES = 16
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic pin_i,
  output logic stable_o,
  output logic rise_o_c
);

  // Raw pin level that corresponds to the inactive logical level
  localparam logic RAW_IDLE = ACTIVE_LOW;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   sync_lvl;

  // Shift the raw pin into the synchroniser chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pin_i};
  end

  // Synchroniser flops start at the inactive level so release is edge-free
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) sync_q <= {SYNC_STAGES{RAW_IDLE}};
    else        sync_q <= sync_d;
  end

  assign sync_lvl = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

`ifdef MMIO_GPIO_DEBOUNCE_EN
  import mmio_gpio_pkg::*;

  localparam int unsigned      CNT_W    = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stable_q;
  logic             stable_d;

  // Count consecutive disagreeing cycles; adopt the new level on the last one
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    rise_o_c = 1'b0;
    if (sync_lvl != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_lvl;
        rise_o_c = sync_lvl;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Stable level and counter state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
`else
  // Without debouncing the last synchroniser flop is the stable value
  assign stable_o = sync_lvl;
  assign rise_o_c = (sync_q[SYNC_STAGES-2] ^ ACTIVE_LOW) & ~sync_lvl;
`endif

endmodule

// File: rtl/mmio_gpio.sv
// Memory-mapped GPIO: OUT/IN/EDGE/MASK registers at BASE_ADDR..BASE_ADDR+3,
// registered loads, rising-edge capture with W1C and a level interrupt.
// Define MMIO_GPIO_DEBOUNCE_EN to build per-bit debounce counters.
module mmio_gpio
  import mmio_gpio_pkg::*;
#(
  parameter logic [31:0]     BASE_ADDR       = 32'h0000_007A,
  parameter int unsigned     OUT_W           = 6,
  parameter int unsigned     IN_W            = 1,
  parameter int unsigned     SYNC_STAGES     = 2,
  parameter int unsigned     DEBOUNCE_CYCLES = 16,
  parameter logic [OUT_W-1:0] OUT_RESET      = '1,
  parameter bit              IN_ACTIVE_LOW   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic             mem_read,
  input  logic             mem_write,
  output logic             hit,
  output logic [31:0]      rdata,
  input  logic [IN_W-1:0]  i_pins,
  output logic [OUT_W-1:0] o_pins,
  output logic             irq
);

  // Elaboration-time parameter range checks
  if (OUT_W < 1 || OUT_W > 32) begin : g_chk_out_w
    $error("mmio_gpio: OUT_W out of range");
  end
  if (IN_W < 1 || IN_W > 32) begin : g_chk_in_w
    $error("mmio_gpio: IN_W out of range");
  end
  if (SYNC_STAGES < 2) begin : g_chk_sync
    $error("mmio_gpio: SYNC_STAGES must be at least 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_chk_deb
    $error("mmio_gpio: DEBOUNCE_CYCLES must be at least 1");
  end

  logic [31:0]      offs_c;
  logic [1:0]       sel_c;
  logic             wr_en_c;
  logic             rd_en_c;
  logic [IN_W-1:0]  in_stable;
  logic [IN_W-1:0]  rise_c;
  logic             unused_wdata;

  logic [OUT_W-1:0] out_q,   out_d;
  logic [IN_W-1:0]  edge_q,  edge_d;
  logic [IN_W-1:0]  mask_q,  mask_d;
  logic [31:0]      rdata_q, rdata_d;

  // Address decode; the wrapping subtract keeps the window exact near 2^32
  assign offs_c  = addr - BASE_ADDR;
  assign hit     = (offs_c < 32'(REG_SPAN));
  assign sel_c   = offs_c[1:0];
  assign wr_en_c = mem_write & hit;
  assign rd_en_c = mem_read & hit;

  assign unused_wdata = ^wdata;

  // Per-bit input conditioning
  for (genvar i = 0; i < IN_W; i++) begin : g_pin
    gpio_debounce #(
      .SYNC_STAGES (SYNC_STAGES),
      .ACTIVE_LOW  (IN_ACTIVE_LOW)
`ifdef MMIO_GPIO_DEBOUNCE_EN
      , .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`endif
    ) u_deb (
      .clk      (clk),
      .reset    (reset),
      .pin_i    (i_pins[i]),
      .stable_o (in_stable[i]),
      .rise_o_c (rise_c[i])
    );
  end

  // Register writes, W1C with edge-set priority, and load data from pre-write state
  always_comb begin
    out_d   = out_q;
    mask_d  = mask_q;
    edge_d  = edge_q;
    rdata_d = '0;
    if (wr_en_c && sel_c == OFF_OUT)  out_d  = wdata[OUT_W-1:0];
    if (wr_en_c && sel_c == OFF_MASK) mask_d = wdata[IN_W-1:0];
    if (wr_en_c && sel_c == OFF_EDGE) edge_d = edge_q & ~wdata[IN_W-1:0];
    edge_d = edge_d | rise_c;
    if (rd_en_c) begin
      case (sel_c)
        OFF_OUT:  rdata_d = 32'(out_q);
        OFF_IN:   rdata_d = 32'(in_stable);
        OFF_EDGE: rdata_d = 32'(edge_q);
        OFF_MASK: rdata_d = 32'(mask_q);
        default:  rdata_d = '0;
      endcase
    end
  end

  // Register state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_q   <= OUT_RESET;
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      out_q   <= out_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_pins = out_q;
  assign rdata  = rdata_q;
  assign irq    = |(edge_q & mask_q);

endmodule

// File: tb/tb_mmio_gpio.sv
// Directed bench for mmio_gpio with default parameters. Latency and glitch
// expectations follow whether MMIO_GPIO_DEBOUNCE_EN is defined.
module tb_mmio_gpio;

`ifdef MMIO_GPIO_DEBOUNCE_EN
  localparam int unsigned LAT         = 18;
  localparam int unsigned GLITCH      = 10;
  localparam logic [31:0] GLITCH_EDGE = 32'd0;
`else
  localparam int unsigned LAT         = 2;
  localparam int unsigned GLITCH      = 1;
  localparam logic [31:0] GLITCH_EDGE = 32'd1;
`endif

  localparam logic [31:0] A_OUT  = 32'h7A;
  localparam logic [31:0] A_IN   = 32'h7B;
  localparam logic [31:0] A_EDGE = 32'h7C;
  localparam logic [31:0] A_MASK = 32'h7D;

  logic        clk;
  logic        reset;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic        hit;
  logic [31:0] rdata;
  logic [0:0]  i_pins;
  logic [5:0]  o_pins;
  logic        irq;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] d;

  mmio_gpio #(
    .BASE_ADDR       (32'h0000_007A),
    .OUT_W           (6),
    .IN_W            (1),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (16),
    .OUT_RESET       (6'h3F),
    .IN_ACTIVE_LOW   (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .wdata     (wdata),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .hit       (hit),
    .rdata     (rdata),
    .i_pins    (i_pins),
    .o_pins    (o_pins),
    .irq       (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; the store lands on the following posedge
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    addr      = a;
    wdata     = v;
    mem_write = 1'b1;
    @(negedge clk);
    mem_write = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  // Called at a negedge; returns rdata one cycle later
  task automatic bus_read(input logic [31:0] a, output logic [31:0] v);
    addr     = a;
    mem_read = 1'b1;
    @(negedge clk);
    v        = rdata;
    mem_read = 1'b0;
    addr     = 32'h0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    i_pins    = 1'b1;
    addr      = 32'h0;
    wdata     = 32'h0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_opins", 32'(o_pins), 32'h3F);
    check_eq("rst_rdata", rdata, 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check_eq("rel_irq", 32'(irq), 32'h0);
    check_eq("rel_opins", 32'(o_pins), 32'h3F);
    bus_read(A_IN, d);   check_eq("rel_in", d, 32'h0);
    bus_read(A_EDGE, d); check_eq("rel_edge", d, 32'h0);

    // Address decode
    addr = 32'h7A; #1 check_eq("hit_7a", 32'(hit), 32'h1);
    addr = 32'h7D; #1 check_eq("hit_7d", 32'(hit), 32'h1);
    addr = 32'h7E; #1 check_eq("hit_7e", 32'(hit), 32'h0);
    addr = 32'h79; #1 check_eq("hit_79", 32'(hit), 32'h0);
    addr = 32'h0;
    @(negedge clk);

    // OUT store/load
    bus_write(A_OUT, 32'h2A);
    check_eq("out_2a", 32'(o_pins), 32'h2A);
    bus_read(A_OUT, d); check_eq("rd_out_2a", d, 32'h2A);
    @(negedge clk);
    check_eq("rdata_idle", rdata, 32'h0);
    bus_write(A_OUT, 32'hFFFF_FFC5);
    check_eq("out_trunc", 32'(o_pins), 32'h05);
    bus_read(A_OUT, d); check_eq("rd_out_05", d, 32'h05);

    // Read and write to the same register in one cycle
    addr = A_OUT; wdata = 32'h13; mem_read = 1'b1; mem_write = 1'b1;
    @(negedge clk);
    check_eq("rw_old_val", rdata, 32'h05);
    check_eq("rw_new_out", 32'(o_pins), 32'h13);
    mem_read = 1'b0; mem_write = 1'b0; addr = 32'h0; wdata = 32'h0;

    // Out-of-window accesses
    bus_write(32'h79, 32'h0);
    bus_write(32'h7E, 32'h3F);
    check_eq("oor_out_kept", 32'(o_pins), 32'h13);
    bus_read(32'h7E, d); check_eq("oor_rd_7e", d, 32'h0);
    bus_read(32'h79, d); check_eq("oor_rd_79", d, 32'h0);
    bus_read(A_MASK, d); check_eq("oor_mask_kept", d, 32'h0);

    // Enable interrupt
    bus_write(A_MASK, 32'hFFFF_FFFF);
    bus_read(A_MASK, d); check_eq("mask_rd", d, 32'h1);
    check_eq("mask_irq0", 32'(irq), 32'h0);

    // Short pulse on the pin
    i_pins = 1'b0;
    repeat (GLITCH) @(negedge clk);
    i_pins = 1'b1;
    repeat (LAT + 4) @(negedge clk);
    bus_read(A_IN, d);   check_eq("glitch_in", d, 32'h0);
    bus_read(A_EDGE, d); check_eq("glitch_edge", d, GLITCH_EDGE);
    check_eq("glitch_irq", 32'(irq), GLITCH_EDGE);
    bus_write(A_EDGE, 32'h1);
    check_eq("glitch_clr", 32'(irq), 32'h0);

    // Real press: exact latency seen through irq
    i_pins = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    check_eq("lat_early", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("lat_exact", 32'(irq), 32'h1);
    bus_read(A_IN, d);   check_eq("press_in", d, 32'h1);
    bus_read(A_EDGE, d); check_eq("press_edge", d, 32'h1);
    bus_read(A_EDGE, d); check_eq("edge_rd_keeps", d, 32'h1);
    bus_write(A_EDGE, 32'h1);
    check_eq("w1c_irq", 32'(irq), 32'h0);
    bus_read(A_EDGE, d); check_eq("w1c_edge", d, 32'h0);

    // Release gives no edge
    i_pins = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check_eq("release_irq", 32'(irq), 32'h0);
    bus_read(A_IN, d); check_eq("release_in", d, 32'h0);

    // W1C landing on the same edge as the set
    i_pins = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    bus_write(A_EDGE, 32'h1);
    check_eq("set_wins_irq", 32'(irq), 32'h1);
    bus_read(A_EDGE, d); check_eq("set_wins_edge", d, 32'h1);
    bus_write(A_EDGE, 32'h1);
    check_eq("set_wins_clr", 32'(irq), 32'h0);

    // Reset in the middle of a debounce window
    i_pins = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    i_pins = 1'b0;
    repeat (LAT / 2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_opins", 32'(o_pins), 32'h3F);
    check_eq("mid_rst_irq", 32'(irq), 32'h0);
    reset = 1'b1;
    bus_write(A_MASK, 32'h1);
    repeat (LAT - 2) @(negedge clk);
    check_eq("mid_rst_early", 32'(irq), 32'h0);
    @(negedge clk);
    check_eq("mid_rst_exact", 32'(irq), 32'h1);
    bus_read(A_OUT, d); check_eq("mid_rst_out", d, 32'h3F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
